lpc_capture_ctrl: RTL and testbench
===================================

LPC_CAPTURE_CTRL -- requirements
Module: lpc_capture_ctrl

Interface
- REQ-001 Parameter DEPTH, default 4, is the number of transaction record slots in the capture FIFO (a power of two, 2..16).
- REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the first byte of every emitted record.
- REQ-003 lpc_clock  input  1  single block clock; all state changes occur on its rising edge.
- REQ-004 lpc_reset  input  1  reset, asynchronous and active-low; 0 resets, 1 runs.
- REQ-005 in_clock  input  1  transaction-complete strobe from the LPC decoder; a 0->1 transition marks a completed transaction.
- REQ-006 in_mode  input  1  transaction type: 1 = I/O, 0 = memory.
- REQ-007 in_direction  input  1  transaction direction: 1 = write, 0 = read.
- REQ-008 in_addr  input  32  transaction address.
- REQ-009 in_data  input  8  transaction data byte.
- REQ-010 enable  input  1  capture enable; 0 ignores new transactions.
- REQ-011 tx_data  output  8  serialized record byte.
- REQ-012 tx_valid  output  1  tx_data is valid.
- REQ-013 tx_ready  input  1  downstream sink accepts tx_data.
- REQ-014 overflow_count  output  8  count of transactions dropped because the FIFO was full.
- REQ-015 fifo_level  output  clog2(DEPTH)+1  number of occupied FIFO slots.

Function
- REQ-016 Capture event: the block SHALL register in_clock into in_clock_d; event = in_clock & ~in_clock_d & enable, evaluated each cycle.
- REQ-017 On an event, the block SHALL sample {in_mode, in_direction, in_addr, in_data} in that same cycle as one 42-bit record.
- REQ-018 Push: an event SHALL write the record when fifo_level < DEPTH, or when a pop occurs in the same cycle; fifo_level is then unchanged by the simultaneous push and pop.
- REQ-019 Drop: an event with the FIFO full and no same-cycle pop SHALL discard the record and increment overflow_count.
- REQ-020 overflow_count SHALL saturate at 8'hFF.
- REQ-021 FIFO pointers SHALL wrap modulo DEPTH.
- REQ-022 FIFO ordering SHALL be strictly first-in, first-out.
- REQ-023 Serializer FSM states: IDLE, HDR, FLAGS, A3, A2, A1, A0, DAT.
- REQ-024 IDLE: when fifo_level != 0, the FSM SHALL pop the head record into a holding register and go to HDR.
- REQ-025 IDLE: tx_valid SHALL be 0.
- REQ-026 In each byte state tx_valid SHALL be 1, and tx_data SHALL be:
  - HDR = SYNC_BYTE
  - FLAGS = {6'b0, mode, direction}
  - A3 = addr[31:24]
  - A2 = addr[23:16]
  - A1 = addr[15:8]
  - A0 = addr[7:0]
  - DAT = data
- REQ-027 Handshake: a byte SHALL transfer in a cycle where tx_valid & tx_ready = 1; the FSM advances only on a transfer.
- REQ-028 tx_data SHALL hold stable while tx_valid = 1 and tx_ready = 0.
- REQ-029 On a DAT transfer, if the FIFO is non-empty, the FSM SHALL pop and go directly to HDR (back-to-back records, no idle cycle); otherwise it SHALL go to IDLE.
- REQ-030 Latency: with the FSM in IDLE and the FIFO empty, HDR SHALL appear on tx_data with tx_valid = 1 in the second cycle after the event cycle.
- REQ-031 Deasserting enable SHALL NOT abort a record in progress or flush the FIFO; queued records are still emitted.
- REQ-032 Every record SHALL be exactly 7 bytes; no partial record is ever emitted outside of reset.

Reset
- REQ-033 While lpc_reset = 0, the block SHALL asynchronously force:
  - tx_valid = 0, tx_data = 0
  - overflow_count = 0, fifo_level = 0
  - FIFO pointers = 0
  - FSM = IDLE
  - in_clock_d = 1
- REQ-034 Because in_clock_d resets to 1, in_clock held high across reset release SHALL NOT produce an event.
- REQ-035 Reset asserted mid-record SHALL abandon the record and all queued records immediately; after release, output resumes only with new events.

Verification
- REQ-036 Single capture: enable = 1, one in_clock pulse with mode = 1, dir = 1, addr = 0x0000_0080, data = 0x3C, tx_ready = 1 -> bytes A5 03 00 00 00 80 3C on consecutive cycles; HDR appears 2 cycles after the edge.
- REQ-037 Backpressure: same stimulus, tx_ready held 0 for 5 cycles during A1 -> tx_data = 0x00 stable with tx_valid = 1 throughout, then the sequence completes unchanged.
- REQ-038 Overflow: DEPTH = 4, tx_ready = 0, 7 pulses -> fifo_level = 4 after pop of the first record; overflow_count = 2 (1 popped + 4 queued + 2 dropped); with 300 drops overflow_count = 0xFF.
- REQ-039 Back-to-back: 3 records queued, tx_ready = 1 -> 21 contiguous valid bytes with no IDLE gap, in push order.
- REQ-040 Reset corners:
  - in_clock = 1 at reset release -> no record emitted.
  - lpc_reset pulsed low during A2 -> tx_valid = 0 immediately, fifo_level = 0, no further bytes.
- REQ-041 Enable gating: enable = 0 during a pulse -> no record and no overflow increment; enable dropped mid-record -> record completes.

Source files
------------

// File: rtl/lpc_capture_if.sv
// Bundle of LPC decoder capture inputs and serialized record output for lpc_capture_ctrl.
// The slave modport is the capture controller; the master modport is the decoder/sink side.
interface lpc_capture_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_clock;
    logic          in_mode;
    logic          in_direction;
    logic [31:0]   in_addr;
    logic [7:0]    in_data;
    logic          enable;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    overflow_count;
    logic [LW-1:0] fifo_level;

    modport master (
        output in_clock, in_mode, in_direction, in_addr, in_data, enable, tx_ready,
        input  tx_data, tx_valid, overflow_count, fifo_level
    );

    modport slave (
        input  in_clock, in_mode, in_direction, in_addr, in_data, enable, tx_ready,
        output tx_data, tx_valid, overflow_count, fifo_level
    );
endinterface

// File: rtl/lpc_capture_ctrl.sv
// LPC transaction capture: edge-detects completed transactions into a record FIFO and
// serializes each record as a 7-byte stream (sync, flags, addr[31:0], data) with valid/ready.
module lpc_capture_ctrl #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic          lpc_clock,
    input  logic          lpc_reset,
    lpc_capture_if.slave  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FLAGS = 3'd2,
        ST_A3    = 3'd3,
        ST_A2    = 3'd4,
        ST_A1    = 3'd5,
        ST_A0    = 3'd6,
        ST_DAT   = 3'd7
    } state_e;

    // Record layout: {mode, direction, addr[31:0], data[7:0]}
    logic [41:0]   mem_q [DEPTH];
    logic [41:0]   record_s;
    logic [41:0]   hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    ovf_q, ovf_d;
    logic          in_clock_dly_q;
    state_e        state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          event_s, xfer_s, pop_s, push_s, drop_s;

    function automatic logic [7:0] byte_sel(input state_e st, input logic [41:0] rec);
        logic [7:0] b;
        case (st)
            ST_HDR:   b = SYNC_BYTE;
            ST_FLAGS: b = {6'b000000, rec[41:40]};
            ST_A3:    b = rec[39:32];
            ST_A2:    b = rec[31:24];
            ST_A1:    b = rec[23:16];
            ST_A0:    b = rec[15:8];
            ST_DAT:   b = rec[7:0];
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    assign record_s = {bus.in_mode, bus.in_direction, bus.in_addr, bus.in_data};
    assign event_s  = bus.in_clock & ~in_clock_dly_q & bus.enable;
    // tx_valid_q is high exactly when the FSM sits in a byte state
    assign xfer_s   = tx_valid_q & bus.tx_ready;

    // Serializer next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != {LW{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR:   if (xfer_s) state_d = ST_FLAGS; else state_d = ST_HDR;
            ST_FLAGS: if (xfer_s) state_d = ST_A3;    else state_d = ST_FLAGS;
            ST_A3:    if (xfer_s) state_d = ST_A2;    else state_d = ST_A3;
            ST_A2:    if (xfer_s) state_d = ST_A1;    else state_d = ST_A2;
            ST_A1:    if (xfer_s) state_d = ST_A0;    else state_d = ST_A1;
            ST_A0:    if (xfer_s) state_d = ST_DAT;   else state_d = ST_A0;
            ST_DAT: begin
                if (xfer_s && (level_q != {LW{1'b0}})) begin
                    pop_s   = 1'b1;
                    state_d = ST_HDR;
                end else if (xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DAT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping, overflow counting and registered output byte selection
    always_comb begin
        push_s   = event_s & ((level_q < DEPTH_L) | pop_s);
        drop_s   = event_s & ~push_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            hold_d   = hold_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop_s && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
        tx_valid_d = (state_d != ST_IDLE);
        tx_data_d  = byte_sel(state_d, hold_d);
    end

    // Control and output registers
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            in_clock_dly_q <= 1'b1;
            wr_ptr_q       <= {AW{1'b0}};
            rd_ptr_q       <= {AW{1'b0}};
            level_q        <= {LW{1'b0}};
            ovf_q          <= 8'h00;
            state_q        <= ST_IDLE;
            hold_q         <= 42'h0;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
        end else begin
            in_clock_dly_q <= bus.in_clock;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            ovf_q          <= ovf_d;
            state_q        <= state_d;
            hold_q         <= hold_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
        end
    end

    // Record storage; contents are only meaningful between the pointers
    always_ff @(posedge lpc_clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= record_s;
        end
    end

    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.overflow_count = ovf_q;
    assign bus.fifo_level     = level_q;
endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Scoreboard bench for lpc_capture_ctrl: a transaction-level model predicts records and bytes,
// a negedge monitor compares every presented byte and the status outputs.
module tb_lpc_capture_ctrl;
    localparam int         DEPTH = 4;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic lpc_clock;
    logic lpc_reset;
    lpc_capture_if #(.DEPTH(DEPTH)) bus ();

    lpc_capture_ctrl #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: queued records, the record being sent (bytes left), expected byte stream
    logic [41:0] mq[$];
    logic [7:0]  exp_q[$];
    int          m_left = 0;
    int          m_ovf  = 0;
    bit          m_prev = 1'b1;

    initial begin
        lpc_clock = 1'b0;
        forever #5 lpc_clock = ~lpc_clock;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_left = 0;
        m_ovf  = 0;
        m_prev = 1'b1;
    endtask

    task automatic model_step();
        bit          ev, xfer, pop, was_full;
        logic [41:0] r;
        if (!lpc_reset) begin
            model_clear();
            return;
        end
        ev       = bus.in_clock && !m_prev && bus.enable;
        xfer     = (m_left > 0) && bus.tx_ready;
        was_full = (mq.size() >= DEPTH);
        pop      = (mq.size() > 0) && ((m_left == 0) || (m_left == 1 && xfer));
        if (pop) begin
            r = mq.pop_front();
            exp_q.push_back(SYNC);
            exp_q.push_back({6'b000000, r[41:40]});
            exp_q.push_back(r[39:32]);
            exp_q.push_back(r[31:24]);
            exp_q.push_back(r[23:16]);
            exp_q.push_back(r[15:8]);
            exp_q.push_back(r[7:0]);
            m_left = 7;
        end else if (xfer) begin
            m_left--;
        end
        if (ev) begin
            if (!was_full || pop) mq.push_back({bus.in_mode, bus.in_direction, bus.in_addr, bus.in_data});
            else if (m_ovf < 255) m_ovf++;
        end
        m_prev = bus.in_clock;
    endtask

    initial begin
        forever begin
            @(posedge lpc_clock);
            model_step();
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge
    initial begin
        forever begin
            @(negedge lpc_clock);
            check("tx_valid", {31'd0, bus.tx_valid}, (m_left > 0) ? 32'd1 : 32'd0);
            check("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
            check("overflow_count", 32'(bus.overflow_count), 32'(m_ovf));
            if (bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t", bus.tx_data, $time);
                end else begin
                    check("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
                    if (bus.tx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [7:0] dt);
        bus.in_mode      = m;
        bus.in_direction = d;
        bus.in_addr      = a;
        bus.in_data      = dt;
        bus.in_clock     = 1'b1;
        tick();
        bus.in_clock     = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        bus.tx_ready = 1'b1;
        while ((mq.size() != 0 || m_left != 0 || bus.tx_valid) && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_errors++;
            $display("FAIL drain: still busy after %0d cycles, expected idle", k);
        end
        check("leftover_bytes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        lpc_reset = 1'b0;
        model_clear();
        tick();
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("rst_overflow", 32'(bus.overflow_count), 32'd0);
        tick();
        lpc_reset = 1'b1;
        tick();
    endtask

    task automatic wait_left(input int want);
        for (int k = 0; k < 60 && m_left != want; k++) tick();
    endtask

    initial begin
        int cnt;
        lpc_reset        = 1'b0;
        bus.in_clock     = 1'b0;
        bus.in_mode      = 1'b0;
        bus.in_direction = 1'b0;
        bus.in_addr      = 32'h0;
        bus.in_data      = 8'h00;
        bus.enable       = 1'b1;
        bus.tx_ready     = 1'b1;
        model_clear();
        do_reset();

        // Single capture with latency check
        pulse(1'b1, 1'b1, 32'h0000_0080, 8'h3C);
        check("latency_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("latency_hdr", 32'(bus.tx_data), 32'h0000_00A5);
        drain(40);

        // Backpressure during A1
        pulse(1'b1, 1'b1, 32'h0000_0080, 8'h3C);
        wait_left(3);
        bus.tx_ready = 1'b0;
        repeat (5) begin
            check("bp_a1_data", 32'(bus.tx_data), 32'd0);
            check("bp_a1_valid", {31'd0, bus.tx_valid}, 32'd1);
            tick();
        end
        drain(40);

        // Back-to-back: three queued records, 21 contiguous bytes
        bus.tx_ready = 1'b0;
        pulse(1'b0, 1'b0, 32'hDEAD_BEEF, 8'h11);
        pulse(1'b1, 1'b0, 32'h0102_0304, 8'h22);
        pulse(1'b0, 1'b1, 32'hCAFE_F00D, 8'h33);
        bus.tx_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.tx_valid) break;
            cnt++;
            tick();
        end
        check("b2b_contiguous", 32'(cnt), 32'd21);
        drain(40);

        // Enable gating
        bus.enable = 1'b0;
        pulse(1'b1, 1'b0, 32'h5555_AAAA, 8'h77);
        repeat (3) tick();
        check("gated_level", 32'(bus.fifo_level), 32'd0);
        check("gated_valid", {31'd0, bus.tx_valid}, 32'd0);
        bus.enable = 1'b1;
        pulse(1'b0, 1'b1, 32'h8765_4321, 8'h99);
        bus.enable = 1'b0;
        drain(40);
        bus.enable = 1'b1;

        // Overflow and saturation
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 7; k++) pulse(k[0], k[1], 32'h1000_0000 + 32'(k), 8'(k));
        check("ovf_level", 32'(bus.fifo_level), 32'd4);
        check("ovf_count", 32'(bus.overflow_count), 32'd2);
        drain(100);
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 305; k++) pulse(1'b0, 1'b0, 32'(k), 8'(k));
        check("ovf_saturate", 32'(bus.overflow_count), 32'h0000_00FF);
        drain(100);

        // Reset release with in_clock held high
        bus.in_clock = 1'b1;
        do_reset();
        repeat (4) tick();
        check("rst_high_noevent", {31'd0, bus.tx_valid}, 32'd0);
        bus.in_clock = 1'b0;
        tick();

        // Reset during A2 with a queued record behind it
        bus.tx_ready = 1'b0;
        pulse(1'b1, 1'b0, 32'h1234_5678, 8'hAB);
        pulse(1'b0, 1'b0, 32'h9ABC_DEF0, 8'hCD);
        bus.tx_ready = 1'b1;
        wait_left(4);
        check("pre_rst_a2", 32'(bus.tx_data), 32'h0000_0034);
        lpc_reset = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_async_level", 32'(bus.fifo_level), 32'd0);
        model_clear();
        tick();
        lpc_reset = 1'b1;
        repeat (12) tick();
        check("post_rst_quiet", {31'd0, bus.tx_valid}, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bus.in_clock     = 1'($urandom_range(0, 2) == 0);
            bus.in_mode      = 1'($urandom_range(0, 1));
            bus.in_direction = 1'($urandom_range(0, 1));
            bus.in_addr      = $urandom;
            bus.in_data      = 8'($urandom_range(0, 255));
            bus.enable       = ($urandom_range(0, 7) != 0);
            bus.tx_ready     = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_clock = 1'b0;
        bus.enable   = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
